fetch_instr_queue: RTL

FETCH_INSTR_QUEUE -- requirements
Module: fetch_instr_queue

---
 rtl/fetch_instr_queue.sv | 87 ++++++++
 1 files changed

// File: rtl/fetch_instr_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular buffer of
// {instr, pc, fault} with registered valid/ready flags and a combinational head read.
module fetch_instr_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc,
    input  logic                     in_fault,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic                     out_fault,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];
    logic          r_mem_fault [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_next;
    logic          w_push;
    logic          w_pop;

    // Flags depend only on the count register, so neither handshake side sees the other combinationally.
    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid  && in_ready  && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // Storage is not reset; the empty-queue output mux hides any stale contents.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_instr[r_tail] <= in_instr;
            r_mem_pc[r_tail]    <= in_pc;
            r_mem_fault[r_tail] <= in_fault;
        end
    end

    assign out_instr = out_valid ? r_mem_instr[r_head] : NOP_INSTR;
    assign out_pc    = out_valid ? r_mem_pc[r_head]    : 32'h0;
    assign out_fault = out_valid ? r_mem_fault[r_head] : 1'b0;

endmodule
